raster_engine: RTL

- GPU-side receiver of the CPU→GPU raster command interface.
- Accepts one command per execute request (FILL, POINT, LINE, RECT) and holds busy while it works.
- Rasterizes the command into single-pixel framebuffer writes, one pixel per clock.
- Sits between the CPU's gpu_* outputs and the framebuffer write port.

---
 rtl/raster_engine_pkg.sv | 22 ++
 rtl/raster_line_step.sv | 65 ++++++
 rtl/raster_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/raster_engine_pkg.sv
// Shared raster command encoding, FSM state encoding and framebuffer geometry.
// The geometry constants are also consumed by the VGA scan-out.
package raster_engine_pkg;

  localparam int RASTER_FB_WIDTH  = 214;
  localparam int RASTER_FB_HEIGHT = 160;
  localparam int RASTER_ADDR_W    = 16;

  typedef enum logic [1:0] {
    CMD_FILL  = 2'd0,
    CMD_POINT = 2'd1,
    CMD_LINE  = 2'd2,
    CMD_RECT  = 2'd3
  } raster_command_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } raster_state_t;

endpackage

// File: rtl/raster_line_step.sv
// Bresenham line walker: loaded from the endpoints on init, advances one
// candidate per step, flags the final candidate and whether the next step moves in y.
module raster_line_step (
  input  logic       clk,
  input  logic       rst_sync,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic       init,
  input  logic       step,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       last,
  output logic       move_y,
  output logic       y_neg
);

  // dy is held negated, so err = dx + dy starts the classic all-octant form.
  logic signed [11:0] dx, dy, err;
  logic signed [12:0] e2, dx_e, dy_e;
  logic [8:0] x_end, y_end;
  logic [7:0] adx, ady;
  logic       x_neg, move_x;

  always_comb begin
    adx    = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    ady    = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    e2     = {err, 1'b0};
    dx_e   = {dx[11], dx};
    dy_e   = {dy[11], dy};
    move_x = (e2 >= dy_e);
    move_y = (e2 <= dx_e);
    last   = (x == x_end) && (y == y_end);
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      x     <= '0;
      y     <= '0;
      x_end <= '0;
      y_end <= '0;
      dx    <= '0;
      dy    <= '0;
      err   <= '0;
      x_neg <= 1'b0;
      y_neg <= 1'b0;
    end else if (init) begin
      x     <= {1'b0, x0};
      y     <= {1'b0, y0};
      x_end <= {1'b0, x1};
      y_end <= {1'b0, y1};
      dx    <= $signed({4'b0000, adx});
      dy    <= -$signed({4'b0000, ady});
      err   <= $signed({4'b0000, adx}) - $signed({4'b0000, ady});
      x_neg <= (x1 < x0);
      y_neg <= (y1 < y0);
    end else if (step && !last) begin
      if (move_x) x <= x_neg ? x - 9'd1 : x + 9'd1;
      if (move_y) y <= y_neg ? y - 9'd1 : y + 9'd1;
      err <= err + (move_x ? dy : 12'sd0) + (move_y ? dx : 12'sd0);
    end
  end

endmodule

// File: rtl/raster_engine.sv
// Raster command receiver: turns FILL/POINT/LINE/RECT into one candidate pixel
// per clock on the framebuffer write port, skipping off-screen candidates.
module raster_engine
  import raster_engine_pkg::*;
#(
  parameter int FB_WIDTH  = RASTER_FB_WIDTH,
  parameter int FB_HEIGHT = RASTER_FB_HEIGHT,
  parameter int ADDR_W    = RASTER_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_sync,
  input  raster_command_t   gpu_command,
  input  logic [7:0]        gpu_x0,
  input  logic [7:0]        gpu_y0,
  input  logic [7:0]        gpu_x1,
  input  logic [7:0]        gpu_y1,
  input  logic [2:0]        gpu_colour,
  input  logic              gpu_execute_request,
  output logic              gpu_busy,
  output logic              fb_write_en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_colour,
  output raster_state_t     state_dbg
);

  // Handshake: a one-cycle gpu_execute_request is taken only in IDLE; gpu_busy
  // is high from the next cycle through the last candidate, and requests while
  // busy are dropped. The cycle gpu_busy falls can already accept a new request.

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

  raster_state_t   state, state_next;
  raster_command_t cmd_r;
  logic [7:0]      x0_r, y0_r, x1_r, y1_r;
  logic [2:0]      colour_r;

  logic [8:0]        xmin, xmax, ymax, cur_x, cur_y;
  logic [ADDR_W-1:0] row_base, start_row;
  logic [8:0]        sx_min, sx_max, sy_min, sy_max;
  logic [8:0]        cand_x, cand_y, line_x, line_y;
  logic              is_line, rect_last, last_cand;
  logic              line_last, line_move_y, line_y_neg;

  raster_line_step u_line (
    .clk      (clk),
    .rst_sync (rst_sync),
    .x0       (x0_r),
    .y0       (y0_r),
    .x1       (x1_r),
    .y1       (y1_r),
    .init     (state == ST_SETUP),
    .step     ((state == ST_DRAW) && is_line),
    .x        (line_x),
    .y        (line_y),
    .last     (line_last),
    .move_y   (line_move_y),
    .y_neg    (line_y_neg)
  );

  // FILL and POINT reuse the rectangle walker with fixed or degenerate bounds.
  always_comb begin
    sx_min = {1'b0, x0_r};
    sx_max = {1'b0, x0_r};
    sy_min = {1'b0, y0_r};
    sy_max = {1'b0, y0_r};
    case (cmd_r)
      CMD_FILL: begin
        sx_min = '0;
        sx_max = 9'(FB_WIDTH - 1);
        sy_min = '0;
        sy_max = 9'(FB_HEIGHT - 1);
      end
      CMD_RECT: begin
        sx_min = {1'b0, (x0_r < x1_r) ? x0_r : x1_r};
        sx_max = {1'b0, (x0_r < x1_r) ? x1_r : x0_r};
        sy_min = {1'b0, (y0_r < y1_r) ? y0_r : y1_r};
        sy_max = {1'b0, (y0_r < y1_r) ? y1_r : y0_r};
      end
      default: ;
    endcase
    start_row = ADDR_W'(sy_min) * ROW_STEP;
    is_line   = (cmd_r == CMD_LINE);
    cand_x    = is_line ? line_x : cur_x;
    cand_y    = is_line ? line_y : cur_y;
    rect_last = (cur_x == xmax) && (cur_y == ymax);
    last_cand = is_line ? line_last : rect_last;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (gpu_execute_request) state_next = ST_SETUP;
      ST_SETUP: state_next = ST_DRAW;
      ST_DRAW:  if (last_cand) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cmd_r    <= CMD_FILL;
      x0_r     <= '0;
      y0_r     <= '0;
      x1_r     <= '0;
      y1_r     <= '0;
      colour_r <= '0;
      xmin     <= '0;
      xmax     <= '0;
      ymax     <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
    end else begin
      case (state)
        ST_IDLE: if (gpu_execute_request) begin
          cmd_r    <= gpu_command;
          x0_r     <= gpu_x0;
          y0_r     <= gpu_y0;
          x1_r     <= gpu_x1;
          y1_r     <= gpu_y1;
          colour_r <= gpu_colour;
        end
        ST_SETUP: begin
          xmin     <= sx_min;
          xmax     <= sx_max;
          ymax     <= sy_max;
          cur_x    <= sx_min;
          cur_y    <= sy_min;
          row_base <= start_row;
        end
        ST_DRAW: begin
          if (is_line) begin
            if (line_move_y && !line_last)
              row_base <= line_y_neg ? row_base - ROW_STEP : row_base + ROW_STEP;
          end else if (!rect_last) begin
            if (cur_x == xmax) begin
              cur_x    <= xmin;
              cur_y    <= cur_y + 9'd1;
              row_base <= row_base + ROW_STEP;
            end else begin
              cur_x <= cur_x + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gpu_busy    = (state != ST_IDLE);
    fb_write_en = (state == ST_DRAW) &&
                  (cand_x < 9'(FB_WIDTH)) && (cand_y < 9'(FB_HEIGHT));
    fb_addr     = (state == ST_DRAW) ? row_base + ADDR_W'(cand_x) : '0;
    fb_colour   = colour_r;
    state_dbg   = state;
  end

endmodule
